// File: rtl/memory_request_unit_pkg.sv
// Shared core typedefs: pipeline stage command, memory-stage bus status and size codes.
// Also holds the store lane-replication helper used by the memory request unit.
package memory_request_unit_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        STALL  = 2'd1,
        BUBBLE = 2'd2
    } pipeline_stat_t;

    typedef enum logic [1:0] {
        SM_IDLE = 2'd0,
        SM_ADDR = 2'd1,
        SM_DATA = 2'd2
    } memory_stat_t;

    localparam logic [1:0] MSIZE_B = 2'd0;
    localparam logic [1:0] MSIZE_H = 2'd1;
    localparam logic [1:0] MSIZE_W = 2'd2;

    // Store data arrives in the low bytes; the bus expects it on every lane.
    function automatic logic [31:0] replicateStore(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            MSIZE_B: replicateStore = {4{wdata[7:0]}};
            MSIZE_H: replicateStore = {2{wdata[15:0]}};
            default: replicateStore = wdata;
        endcase
    endfunction

endpackage

// File: rtl/memory_request_unit_load_align.sv
// mem_load_align: combinational lane select and zero/sign extension of raw load data.
module mem_load_align
    import memory_request_unit_pkg::*;
(
    input  logic [31:0] rawData,
    input  logic [1:0]  addrLow,
    input  logic [1:0]  size,
    input  logic        isSigned,
    output logic [31:0] result
);
    logic [7:0]  byteLane [4];
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byteLane[gi] = rawData[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byteSel = byteLane[addrLow];
        halfSel = addrLow[1] ? rawData[31:16] : rawData[15:0];
        case (size)
            MSIZE_B: result = {{24{isSigned & byteSel[7]}}, byteSel};
            MSIZE_H: result = {{16{isSigned & halfSel[15]}}, halfSel};
            default: result = rawData;
        endcase
    end

endmodule

// File: rtl/memory_request_unit.sv
// Memory-stage data-bus initiator: issues one load/store per captured op on the SRAM-like bus.
// Optional MEM_ALIGN_CHECK_EN raises AdEL/AdES at capture and suppresses the access.
module memory_request_unit
    import memory_request_unit_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  pipeline_stat_t MemoryStat,
    input  logic           in_valid,
    input  logic           in_wr,
    input  logic [1:0]     in_size,
    input  logic           in_signed,
    input  logic [31:0]    in_addr,
    input  logic [31:0]    in_wdata,
    input  logic           in_excp,
    output logic           data_req,
    output logic           data_wr,
    output logic [1:0]     data_size,
    output logic [31:0]    data_addr,
    output logic [31:0]    data_wdata,
    input  logic           data_addr_ok,
    input  logic           data_data_ok,
    input  logic [31:0]    data_rdata,
    output memory_stat_t   stat,
    output logic [31:0]    load_result,
    output logic           result_valid,
    output logic [1:0]     align_excp
);
    memory_stat_t stateReg, stateNext;
    logic         wrReg, signedReg, liveReg, resultValidReg;
    logic [1:0]   sizeReg;
    logic [31:0]  addrReg, wdataReg, loadResultReg, alignedData;
    logic         captureEn, bubbleEn, misaligned, opOk, dataDone;

    // A busy stage only accepts a new op once it is back in SM_IDLE; NORMAL while busy acts as STALL.
    assign captureEn = (MemoryStat == NORMAL) && (stateReg == SM_IDLE);
    assign bubbleEn  = (MemoryStat == BUBBLE);
    assign opOk      = in_valid && !in_excp && !misaligned;
    assign dataDone  = data_data_ok &&
                       (((stateReg == SM_ADDR) && data_addr_ok) || (stateReg == SM_DATA));

`ifdef MEM_ALIGN_CHECK_EN
    logic [1:0] alignExcpReg;

    assign misaligned = in_valid && !in_excp &&
                        (((in_size == MSIZE_H) && in_addr[0]) ||
                         ((in_size == MSIZE_W) && (in_addr[1:0] != 2'b00)));
    assign align_excp = alignExcpReg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            alignExcpReg <= 2'b00;
        end else if (captureEn) begin
            alignExcpReg <= misaligned ? {in_wr, !in_wr} : 2'b00;
        end else if (bubbleEn) begin
            alignExcpReg <= 2'b00;
        end
    end
`else
    assign misaligned = 1'b0;
    assign align_excp = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stateReg <= SM_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // An accepted address means a live transaction, so even a BUBBLE must wait for its data phase.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            SM_IDLE: if (captureEn) stateNext = opOk ? SM_ADDR : SM_IDLE;
            SM_ADDR: begin
                if (data_addr_ok) stateNext = data_data_ok ? SM_IDLE : SM_DATA;
                else if (bubbleEn) stateNext = SM_IDLE;
            end
            SM_DATA: if (data_data_ok) stateNext = SM_IDLE;
            default: stateNext = SM_IDLE;
        endcase
    end

    mem_load_align u_align (
        .rawData  (data_rdata),
        .addrLow  (addrReg[1:0]),
        .size     (sizeReg),
        .isSigned (signedReg),
        .result   (alignedData)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wrReg          <= 1'b0;
            sizeReg        <= 2'd0;
            signedReg      <= 1'b0;
            addrReg        <= 32'd0;
            wdataReg       <= 32'd0;
            liveReg        <= 1'b0;
            loadResultReg  <= 32'd0;
            resultValidReg <= 1'b0;
        end else if (captureEn) begin
            wrReg          <= in_wr;
            sizeReg        <= in_size;
            signedReg      <= in_signed;
            addrReg        <= in_addr;
            wdataReg       <= replicateStore(in_size, in_wdata);
            liveReg        <= opOk;
            resultValidReg <= 1'b0;
        end else if (bubbleEn) begin
            // liveReg cleared here makes a draining data phase discard its data.
            wrReg          <= 1'b0;
            sizeReg        <= 2'd0;
            signedReg      <= 1'b0;
            addrReg        <= 32'd0;
            wdataReg       <= 32'd0;
            liveReg        <= 1'b0;
            resultValidReg <= 1'b0;
        end else if (dataDone && liveReg && !wrReg) begin
            loadResultReg  <= alignedData;
            resultValidReg <= 1'b1;
        end
    end

    assign data_req     = (stateReg == SM_ADDR);
    assign data_wr      = wrReg;
    assign data_size    = sizeReg;
    assign data_addr    = addrReg;
    assign data_wdata   = wdataReg;
    assign stat         = stateReg;
    assign load_result  = loadResultReg;
    assign result_valid = resultValidReg;

endmodule

// File: tb/tb_memory_request_unit.sv
// Self-checking bench for memory_request_unit: directed scenarios plus randomized ops vs a reference model.
module tb_memory_request_unit;
    import memory_request_unit_pkg::*;

    logic           clk = 1'b0;
    logic           resetn;
    pipeline_stat_t MemoryStat;
    logic           in_valid, in_wr, in_signed, in_excp;
    logic [1:0]     in_size;
    logic [31:0]    in_addr, in_wdata;
    logic           data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]     data_size;
    logic [31:0]    data_addr, data_wdata, data_rdata;
    memory_stat_t   stat;
    logic [31:0]    load_result;
    logic           result_valid;
    logic [1:0]     align_excp;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    memory_request_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .MemoryStat   (MemoryStat),
        .in_valid     (in_valid),
        .in_wr        (in_wr),
        .in_size      (in_size),
        .in_signed    (in_signed),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_excp      (in_excp),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .stat         (stat),
        .load_result  (load_result),
        .result_valid (result_valid),
        .align_excp   (align_excp)
    );

    // Reference: shift the addressed lane down, mask to width, subtract 2^width for negative signed values.
    function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [31:0] addr,
                                               input logic [1:0] size, input logic sgn);
        longint v;
        longint width;
        if (size == 2'd0) begin
            v = longint'((raw >> (8 * addr[1:0])) & 32'h0000_00FF);
            width = 8;
        end else if (size == 2'd1) begin
            v = longint'((raw >> (16 * addr[1])) & 32'h0000_FFFF);
            width = 16;
        end else begin
            return raw;
        end
        if (sgn && v >= (longint'(1) << (width - 1))) v = v - (longint'(1) << width);
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    task automatic drive_idle();
        MemoryStat   = STALL;
        in_valid     = 1'b0;
        in_wr        = 1'b0;
        in_size      = 2'd0;
        in_signed    = 1'b0;
        in_addr      = 32'd0;
        in_wdata     = 32'd0;
        in_excp      = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
    endtask

    task automatic present_op(input logic wr, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata);
        MemoryStat = NORMAL;
        in_valid   = 1'b1;
        in_wr      = wr;
        in_size    = size;
        in_signed  = sgn;
        in_addr    = addr;
        in_wdata   = wdata;
        in_excp    = 1'b0;
    endtask

    // Captures one op, then plays the bus slave with the given waits; reports what it observed.
    task automatic run_op(input logic wr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                          input int addrDelay, input int dataDelay,
                          output int busyCycles, output int reqCycles, output int fieldErrs,
                          output logic rv, output logic [31:0] lr, output logic timedOut);
        logic [31:0] expWdata;
        int addrWait, dataWait, c;
        logic done;
        expWdata = model_store(size, wdata);
        @(negedge clk);
        present_op(wr, size, sgn, addr, wdata);
        @(negedge clk);
        MemoryStat = STALL;
        in_valid   = 1'b0;
        busyCycles = 0; reqCycles = 0; fieldErrs = 0;
        addrWait = 0; dataWait = 0; c = 0;
        rv = 1'b0; lr = 32'd0; timedOut = 1'b1; done = 1'b0;
        while (!done && c < 40) begin
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            if (data_req) reqCycles++;
            if (stat == SM_IDLE) begin
                timedOut = 1'b0;
                rv = result_valid;
                lr = load_result;
                done = 1'b1;
            end else begin
                busyCycles++;
                if (stat == SM_ADDR) begin
                    if (data_addr !== addr || data_size !== size || data_wr !== wr || data_wdata !== expWdata)
                        fieldErrs++;
                    if (addrWait == addrDelay) begin
                        data_addr_ok = 1'b1;
                        if (dataDelay == 0) begin data_data_ok = 1'b1; data_rdata = rdata; end
                    end else begin
                        addrWait++;
                    end
                end else begin
                    dataWait++;
                    if (dataWait == dataDelay) begin data_data_ok = 1'b1; data_rdata = rdata; end
                end
                c++;
                @(negedge clk);
            end
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        $display("op wr=%0d size=%0d signed=%0d addr=%08h waits=%0d/%0d busy=%0d req=%0d rv=%0d result=%08h",
                 wr, size, sgn, addr, addrDelay, dataDelay, busyCycles, reqCycles, rv, lr);
    endtask

    task automatic test_reset();
        drive_idle();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checkCount++; if (stat !== SM_IDLE) $display("FAIL reset_stat got=%0d want=%0d", stat, SM_IDLE); else passCount++;
        checkCount++; if (data_req !== 1'b0) $display("FAIL reset_req got=%0b want=0", data_req); else passCount++;
        checkCount++; if (data_wr !== 1'b0) $display("FAIL reset_wr got=%0b want=0", data_wr); else passCount++;
        checkCount++; if (data_size !== 2'd0) $display("FAIL reset_size got=%0d want=0", data_size); else passCount++;
        checkCount++; if (data_addr !== 32'd0) $display("FAIL reset_addr got=%08h want=0", data_addr); else passCount++;
        checkCount++; if (data_wdata !== 32'd0) $display("FAIL reset_wdata got=%08h want=0", data_wdata); else passCount++;
        checkCount++; if (load_result !== 32'd0) $display("FAIL reset_result got=%08h want=0", load_result); else passCount++;
        checkCount++; if (result_valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", result_valid); else passCount++;
        checkCount++; if (align_excp !== 2'b00) $display("FAIL reset_excp got=%02b want=00", align_excp); else passCount++;
        resetn = 1'b1;
    endtask

    task automatic test_word_load();
        int busy, req, ferr; logic rv, to; logic [31:0] lr;
        run_op(1'b0, MSIZE_W, 1'b0, 32'h1000, 32'd0, 32'hDEADBEEF, 0, 0, busy, req, ferr, rv, lr, to);
        checkCount++; if (to !== 1'b0) $display("FAIL word_timeout got=%0b want=0", to); else passCount++;
        checkCount++; if (busy != 1) $display("FAIL word_busy got=%0d want=1", busy); else passCount++;
        checkCount++; if (req != 1) $display("FAIL word_req_cycles got=%0d want=1", req); else passCount++;
        checkCount++; if (rv !== 1'b1) $display("FAIL word_valid got=%0b want=1", rv); else passCount++;
        checkCount++; if (lr !== 32'hDEADBEEF) $display("FAIL word_result got=%08h want=deadbeef", lr); else passCount++;
    endtask

    task automatic test_signed_byte_load();
        int busy, req, ferr; logic rv, to; logic [31:0] lr;
        run_op(1'b0, MSIZE_B, 1'b1, 32'h1003, 32'd0, 32'h80112233, 2, 3, busy, req, ferr, rv, lr, to);
        checkCount++; if (busy != 6) $display("FAIL sbyte_busy got=%0d want=6", busy); else passCount++;
        checkCount++; if (req != 3) $display("FAIL sbyte_req_cycles got=%0d want=3", req); else passCount++;
        checkCount++; if (ferr != 0) $display("FAIL sbyte_field_stable got=%0d want=0", ferr); else passCount++;
        checkCount++; if (lr !== 32'hFFFFFF80 || rv !== 1'b1) $display("FAIL sbyte_result got=%08h/%0b want=ffffff80/1", lr, rv); else passCount++;
    endtask

    task automatic test_half_store();
        int busy, req, ferr; logic rv, to; logic [31:0] lr;
        // Fields are sampled against {wr=1, size=1, addr=2002, wdata=ABCDABCD} in every SM_ADDR cycle.
        run_op(1'b1, MSIZE_H, 1'b0, 32'h2002, 32'h0000ABCD, 32'h0, 1, 1, busy, req, ferr, rv, lr, to);
        checkCount++; if (ferr != 0) $display("FAIL hstore_fields got=%0d bad cycles want=0", ferr); else passCount++;
        checkCount++; if (req != 2) $display("FAIL hstore_req_cycles got=%0d want=2", req); else passCount++;
        checkCount++; if (rv !== 1'b0) $display("FAIL hstore_valid got=%0b want=0", rv); else passCount++;
    endtask

    task automatic test_stall_hold();
        int busy, req, ferr, reqSeen; logic rv, to; logic [31:0] lr;
        run_op(1'b0, MSIZE_H, 1'b0, 32'h1102, 32'd0, 32'hCAFE1234, 0, 1, busy, req, ferr, rv, lr, to);
        checkCount++; if (lr !== 32'h0000CAFE) $display("FAIL stall_first_result got=%08h want=0000cafe", lr); else passCount++;
        reqSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (data_req !== 1'b0) reqSeen++;
            checkCount++; if (load_result !== 32'h0000CAFE || result_valid !== 1'b1)
                $display("FAIL stall_hold_result got=%08h/%0b want=0000cafe/1", load_result, result_valid); else passCount++;
        end
        checkCount++; if (reqSeen != 0) $display("FAIL stall_reissue got=%0d req cycles want=0", reqSeen); else passCount++;
        MemoryStat = NORMAL;
        @(negedge clk);
        MemoryStat = STALL;
        checkCount++; if (result_valid !== 1'b0) $display("FAIL normal_clears_valid got=%0b want=0", result_valid); else passCount++;
    endtask

    task automatic test_bubble();
        // BUBBLE in SM_ADDR without addr_ok drops the request.
        @(negedge clk);
        present_op(1'b0, MSIZE_W, 1'b0, 32'h4000, 32'd0);
        @(negedge clk);
        checkCount++; if (data_req !== 1'b1) $display("FAIL bubble_addr_req got=%0b want=1", data_req); else passCount++;
        MemoryStat = BUBBLE; in_valid = 1'b0;
        @(negedge clk);
        MemoryStat = STALL;
        checkCount++; if (stat !== SM_IDLE || data_req !== 1'b0) $display("FAIL bubble_addr_drop got=%0d/%0b want=0/0", stat, data_req); else passCount++;
        // BUBBLE in SM_DATA drains the data phase and discards it.
        present_op(1'b0, MSIZE_W, 1'b0, 32'h5000, 32'd0);
        @(negedge clk);
        MemoryStat = STALL; in_valid = 1'b0;
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        checkCount++; if (stat !== SM_DATA) $display("FAIL bubble_enter_data got=%0d want=%0d", stat, SM_DATA); else passCount++;
        MemoryStat = BUBBLE;
        @(negedge clk);
        MemoryStat = STALL;
        checkCount++; if (stat !== SM_DATA || data_req !== 1'b0) $display("FAIL bubble_drain_hold got=%0d/%0b want=2/0", stat, data_req); else passCount++;
        data_data_ok = 1'b1; data_rdata = 32'h12345678;
        @(negedge clk);
        data_data_ok = 1'b0;
        checkCount++; if (stat !== SM_IDLE || result_valid !== 1'b0) $display("FAIL bubble_discard got=%0d/%0b want=0/0", stat, result_valid); else passCount++;
    endtask

    task automatic test_excp_and_align();
        int busy, req, ferr; logic rv, to; logic [31:0] lr;
        @(negedge clk);
        present_op(1'b0, MSIZE_W, 1'b0, 32'h6000, 32'd0);
        in_excp = 1'b1;
        @(negedge clk);
        drive_idle();
        checkCount++; if (stat !== SM_IDLE || data_req !== 1'b0) $display("FAIL excp_suppress got=%0d/%0b want=0/0", stat, data_req); else passCount++;
`ifdef MEM_ALIGN_CHECK_EN
        present_op(1'b0, MSIZE_W, 1'b0, 32'h3002, 32'd0);
        @(negedge clk);
        drive_idle();
        checkCount++; if (align_excp !== 2'b01) $display("FAIL align_adel got=%02b want=01", align_excp); else passCount++;
        checkCount++; if (data_req !== 1'b0 || stat !== SM_IDLE) $display("FAIL align_no_req got=%0b/%0d want=0/0", data_req, stat); else passCount++;
        MemoryStat = NORMAL;
        @(negedge clk);
        MemoryStat = STALL;
`else
        present_op(1'b0, MSIZE_W, 1'b0, 32'h3002, 32'd0);
        @(negedge clk);
        drive_idle();
        checkCount++; if (data_req !== 1'b1 || data_addr !== 32'h3002) $display("FAIL misaligned_passthru got=%0b/%08h want=1/00003002", data_req, data_addr); else passCount++;
        checkCount++; if (align_excp !== 2'b00) $display("FAIL align_tied got=%02b want=00", align_excp); else passCount++;
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BADF00D;
        @(negedge clk);
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
`endif
        // Mid-transaction reset returns everything to idle in one edge.
        present_op(1'b1, MSIZE_W, 1'b0, 32'h7000, 32'h55AA55AA);
        @(negedge clk);
        MemoryStat = STALL; in_valid = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checkCount++; if (stat !== SM_IDLE || data_req !== 1'b0 || data_addr !== 32'd0)
            $display("FAIL midreset got=%0d/%0b/%08h want=0/0/00000000", stat, data_req, data_addr); else passCount++;
        run_op(1'b0, MSIZE_B, 1'b0, 32'h7001, 32'd0, 32'h00C30000, 0, 0, busy, req, ferr, rv, lr, to);
        checkCount++; if (lr !== 32'h00000000 || rv !== 1'b1) $display("FAIL after_reset_load got=%08h/%0b want=00000000/1", lr, rv); else passCount++;
    endtask

    task automatic test_random_ops();
        int busy, req, ferr, ad, dd; logic rv, to; logic [31:0] lr, addr, wd, rd, exp;
        logic wr, sgn; logic [1:0] size;
        for (int n = 0; n < 24; n++) begin
            wr   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 2));
            addr = $urandom;
            if (size == 2'd1) addr[0] = 1'b0;
            if (size == 2'd2) addr[1:0] = 2'b00;
            wd = $urandom; rd = $urandom;
            ad = $urandom_range(0, 3); dd = $urandom_range(0, 3);
            run_op(wr, size, sgn, addr, wd, rd, ad, dd, busy, req, ferr, rv, lr, to);
            exp = model_load(rd, addr, size, sgn);
            checkCount++; if (to !== 1'b0 || busy != ad + 1 + dd || req != ad + 1)
                $display("FAIL rand_timing n=%0d got=%0b/%0d/%0d want=0/%0d/%0d", n, to, busy, req, ad + 1 + dd, ad + 1); else passCount++;
            checkCount++; if (ferr != 0) $display("FAIL rand_fields n=%0d got=%0d want=0", n, ferr); else passCount++;
            checkCount++; if (rv !== !wr || (!wr && lr !== exp))
                $display("FAIL rand_result n=%0d got=%08h/%0b want=%08h/%0b", n, lr, rv, exp, !wr); else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_signed_byte_load();
        test_half_store();
        test_stall_hold();
        test_bubble();
        test_excp_and_align();
        test_random_ops();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
